// File: rtl/div_share_arb_pkg.sv
// Shared types and elaboration-time helpers for the divider-sharing arbiter.
package div_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned MAX_DATA_W = 64;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // All-ones pattern of width w, returned right-aligned in MAX_DATA_W bits.
    function automatic logic [MAX_DATA_W-1:0] dbz_quotient(input int unsigned w);
        if (w >= MAX_DATA_W) begin
            return '1;
        end
        return (MAX_DATA_W'(1) << w) - MAX_DATA_W'(1);
    endfunction

endpackage

// File: rtl/div_share_arb_if.sv
// Requester and divider side signals of the divider-sharing arbiter.
interface div_share_arb_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SIZE_DATA = 32
);
    logic [NUM_REQ-1:0]           i_req_valid;
    logic [NUM_REQ-1:0]           o_req_ready;
    logic [NUM_REQ*SIZE_DATA-1:0] i_req_dividend;
    logic [NUM_REQ*SIZE_DATA-1:0] i_req_divisor;
    logic [NUM_REQ-1:0]           o_resp_valid;
    logic [SIZE_DATA-1:0]         o_resp_quotient;
    logic [SIZE_DATA-1:0]         o_resp_remainder;
    logic                         o_resp_dbz;
    logic                         o_resp_err;
    logic                         o_div_en;
    logic [SIZE_DATA-1:0]         o_div_dividend;
    logic [SIZE_DATA-1:0]         o_div_divisor;
    logic [SIZE_DATA-1:0]         i_div_quotient;
    logic [SIZE_DATA-1:0]         i_div_remainder;
    logic                         i_div_valid;
    logic                         o_busy;

    // Arbiter view.
    modport master (
        input  i_req_valid, i_req_dividend, i_req_divisor,
        input  i_div_quotient, i_div_remainder, i_div_valid,
        output o_req_ready, o_resp_valid, o_resp_quotient, o_resp_remainder,
        output o_resp_dbz, o_resp_err, o_div_en, o_div_dividend, o_div_divisor, o_busy
    );

    // Requesters plus divider view.
    modport slave (
        output i_req_valid, i_req_dividend, i_req_divisor,
        output i_div_quotient, i_div_remainder, i_div_valid,
        input  o_req_ready, o_resp_valid, o_resp_quotient, o_resp_remainder,
        input  o_resp_dbz, o_resp_err, o_div_en, o_div_dividend, o_div_divisor, o_busy
    );
endinterface

// File: rtl/div_share_arb_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the pointer.
module rr_arbiter
    import div_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               grant_any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant     = '0;
        idx       = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (en && !grant_any && req[cand]) begin
                grant_any   = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arb.sv
// Shares one multi-cycle divider among NUM_REQ requesters, one operation at a time,
// with local divide-by-zero handling and a divider timeout.
module div_share_arb
    import div_share_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SIZE_DATA = 32,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    div_share_arb_if.master bus
);

    localparam int unsigned ID_W  = id_width(NUM_REQ);
    localparam int unsigned CNT_W = id_width(TIMEOUT);
    localparam logic [SIZE_DATA-1:0] DBZ_QUOTIENT = SIZE_DATA'(dbz_quotient(SIZE_DATA));
    localparam logic [CNT_W-1:0]     CNT_LAST     = CNT_W'(TIMEOUT - 1);

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      id;
    logic [CNT_W-1:0]     cnt;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;
    logic [SIZE_DATA-1:0] dividend_arr [NUM_REQ];
    logic [SIZE_DATA-1:0] divisor_arr  [NUM_REQ];
    logic [SIZE_DATA-1:0] sel_dividend;
    logic [SIZE_DATA-1:0] sel_divisor;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign dividend_arr[k] = bus.i_req_dividend[k*SIZE_DATA +: SIZE_DATA];
        assign divisor_arr[k]  = bus.i_req_divisor[k*SIZE_DATA +: SIZE_DATA];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req       (bus.i_req_valid),
        .ptr       (ptr),
        .en        (state == IDLE),
        .grant     (gnt),
        .idx       (gnt_idx),
        .grant_any (gnt_any)
    );

    // Accept is combinational so the requester sees it in the grant cycle.
    assign bus.o_req_ready = gnt;
    assign sel_dividend    = dividend_arr[gnt_idx];
    assign sel_divisor     = divisor_arr[gnt_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                <= IDLE;
            ptr                  <= ID_W'(NUM_REQ - 1);
            id                   <= '0;
            cnt                  <= '0;
            bus.o_resp_valid     <= '0;
            bus.o_resp_quotient  <= '0;
            bus.o_resp_remainder <= '0;
            bus.o_resp_dbz       <= 1'b0;
            bus.o_resp_err       <= 1'b0;
            bus.o_div_en         <= 1'b0;
            bus.o_div_dividend   <= '0;
            bus.o_div_divisor    <= '0;
            bus.o_busy           <= 1'b0;
        end else begin
            bus.o_div_en     <= 1'b0;
            bus.o_resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        ptr        <= gnt_idx;
                        id         <= gnt_idx;
                        bus.o_busy <= 1'b1;
                        // A zero divisor is answered locally without starting the divider.
                        if (sel_divisor == '0) begin
                            bus.o_resp_quotient  <= DBZ_QUOTIENT;
                            bus.o_resp_remainder <= sel_dividend;
                            bus.o_resp_dbz       <= 1'b1;
                            bus.o_resp_err       <= 1'b0;
                            bus.o_resp_valid     <= gnt;
                            state                <= RESP;
                        end else begin
                            bus.o_div_dividend <= sel_dividend;
                            bus.o_div_divisor  <= sel_divisor;
                            bus.o_div_en       <= 1'b1;
                            state              <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.i_div_valid) begin
                        bus.o_resp_quotient  <= bus.i_div_quotient;
                        bus.o_resp_remainder <= bus.i_div_remainder;
                        bus.o_resp_dbz       <= 1'b0;
                        bus.o_resp_err       <= 1'b0;
                        bus.o_resp_valid     <= NUM_REQ'(1) << id;
                        state                <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus.o_resp_quotient  <= '0;
                        bus.o_resp_remainder <= '0;
                        bus.o_resp_dbz       <= 1'b0;
                        bus.o_resp_err       <= 1'b1;
                        bus.o_resp_valid     <= NUM_REQ'(1) << id;
                        state                <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
